uart_tx_feeder: RTL and testbench

- Byte-buffering front end that sits directly upstream of the UART TX controller FSM.
- Accepts bytes from the system side through a write strobe and stores them in a synchronous FIFO.
- Launches one byte at a time into the TX path: drives the parallel data bus and a single-cycle data-valid pulse, then tracks the TX busy flag until the frame completes.
- Lets software burst bytes without polling busy; gaps between frames appear as extended idle/stop time on the line.

---
 rtl/uart_tx_pkg.sv | 15 +
 rtl/uart_tx_feeder_sync_fifo.sv | 74 +++++++
 rtl/uart_tx_feeder.sv | 109 ++++++++++
 tb/tb_uart_tx_feeder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX path: feeder state encoding and the
// default character width.
package uart_tx_pkg;

  localparam int UART_DATA_WIDTH = 8;

  // Encoding is fixed so the TX FSM package can reference the same constants.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_e;

endpackage : uart_tx_pkg

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock FIFO with occupancy count and a registered overflow pulse.
// A write while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_accept;
  logic                  rd_accept;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  assign wr_accept = wr_en_i && !full_o;
  assign rd_accept = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d   = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_accept ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d = wr_en_i && full_o;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count and pointers decide
  // what is valid, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule : sync_fifo

// File: rtl/uart_tx_feeder.sv
// Byte buffer in front of the UART TX FSM: queues system writes and launches
// one byte per frame, retrying a launch whose busy acknowledge never arrives.
module uart_tx_feeder
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   tx_busy,
  output logic                   tx_data_valid,
  output logic [DATA_WIDTH-1:0]  tx_p_data,
  output logic                   ack_err
);

  localparam int                CNT_W   = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  feeder_state_e         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  valid_q, valid_d;
  logic                  ack_err_q, ack_err_d;
  logic                  pop;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] head_data;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_en_i    (pop),
    .rd_data_o  (head_data),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (fifo_count),
    .overflow_o (overflow)
  );

  assign tx_data_valid = valid_q;
  assign tx_p_data     = p_data_q;
  assign ack_err       = ack_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!empty && !tx_busy) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)              state_d = WAIT_DONE;
        else if (cnt_q == TO_LAST) state_d = LAUNCH;
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    pop       = (state_q == IDLE) && !empty && !tx_busy;
    timeout   = (state_q == WAIT_BUSY) && !tx_busy && (cnt_q == TO_LAST);
    cnt_d     = cnt_q;
    if (state_q == LAUNCH) begin
      cnt_d = '0;
    end else if ((state_q == WAIT_BUSY) && !tx_busy && !timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Retry relaunches keep the held byte; only a real pop reloads it.
    p_data_d  = pop ? head_data : p_data_q;
    valid_d   = (state_d == LAUNCH);
    ack_err_d = timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      p_data_q  <= p_data_d;
      valid_q   <= valid_d;
      ack_err_q <= ack_err_d;
    end
  end

endmodule : uart_tx_feeder

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a FIFO vector table plus hand-written
// sequences for launch latency, ack timeout retry and reset mid-frame.
module tb_uart_tx_feeder;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       tx_busy;
  logic       tx_data_valid;
  logic [7:0] tx_p_data;
  logic       ack_err;

  logic       manual_busy;
  logic       busy_model;
  logic       model_en;
  int         model_len;
  logic [7:0] sent_q[$];
  int         stable_err;
  int         valid_cnt;
  int         viol;
  logic       prev_valid;

  int checks;
  int errors;

  assign tx_busy = manual_busy | busy_model;

  uart_tx_feeder #(
    .DATA_WIDTH  (8),
    .DEPTH       (16),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .empty         (empty),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .tx_busy       (tx_busy),
    .tx_data_valid (tx_data_valid),
    .tx_p_data     (tx_p_data),
    .ack_err       (ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // TX FSM model: busy rises the cycle after a launch and holds model_len cycles.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (model_en && tx_data_valid) begin
        sent_q.push_back(tx_p_data);
        @(posedge clk);
        #1;
        busy_model = 1'b1;
        for (int i = 0; i < model_len; i++) begin
          @(posedge clk);
          #1;
          if (tx_p_data !== sent_q[$]) stable_err++;
        end
        busy_model = 1'b0;
      end
    end
  end

  // Launch monitor: counts pulses, flags valid during busy or longer than a cycle.
  initial begin
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_data_valid) valid_cnt++;
      if (tx_data_valid && (tx_busy || prev_valid)) viol++;
      prev_valid = tx_data_valid;
    end
  end

  initial begin
    int         budget;
    int         vc;
    logic [7:0] first;

    checks      = 0;
    errors      = 0;
    stable_err  = 0;
    valid_cnt   = 0;
    viol        = 0;
    model_en    = 1'b0;
    model_len   = 4;
    manual_busy = 1'b0;
    rst         = 1'b0;
    wr_en       = 1'b0;
    wr_data     = 8'h00;

    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{1'b1, 8'(i), 5'(i + 1), (i == 15), 1'b0, 1'b0};
    end
    vecs[16] = '{1'b1, 8'hFF, 5'd16, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b0};

    // Reset with a write strobe held: nothing may be stored.
    #1;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    repeat (3) step();
    check("rst_count", fifo_count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", tx_data_valid, 0);
    check("rst_pdata", tx_p_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ackerr", ack_err, 0);
    wr_en = 1'b0;
    rst   = 1'b1;
    step();
    check("rst_nostore", fifo_count, 0);

    // Single byte: valid two cycles after the write, one cycle wide.
    model_en  = 1'b1;
    model_len = 100;
    wr_en     = 1'b1;
    wr_data   = 8'hA5;
    step();
    check("single_count", fifo_count, 1);
    check("single_valid_early", tx_data_valid, 0);
    wr_en = 1'b0;
    step();
    check("single_valid", tx_data_valid, 1);
    check("single_pdata", tx_p_data, 8'hA5);
    check("single_empty", empty, 1);
    step();
    check("single_valid_width", tx_data_valid, 0);
    repeat (110) step();
    first = (sent_q.size() > 0) ? sent_q[0] : 8'hxx;
    check("single_frames", sent_q.size(), 1);
    check("single_sent", first, 8'hA5);
    check("single_stable", stable_err, 0);
    check("single_pdata_after", tx_p_data, 8'hA5);

    // Burst fill with TX held busy, then drain through the model.
    sent_q.delete();
    model_len   = 4;
    manual_busy = 1'b1;
    for (int i = 0; i < 18; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].data;
      step();
      check($sformatf("tbl%0d_count", i), fifo_count, vecs[i].count);
      check($sformatf("tbl%0d_full", i), full, vecs[i].full);
      check($sformatf("tbl%0d_empty", i), empty, vecs[i].empty);
      check($sformatf("tbl%0d_ovf", i), overflow, vecs[i].ovf);
      check($sformatf("tbl%0d_valid", i), tx_data_valid, 0);
    end
    wr_en       = 1'b0;
    manual_busy = 1'b0;
    budget      = 0;
    while (sent_q.size() < 16 && budget < 400) begin
      step();
      budget++;
    end
    repeat (12) step();
    check("burst_frames", sent_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      first = (sent_q.size() > i) ? sent_q[i] : 8'hxx;
      check($sformatf("burst_order%0d", i), first, 8'(i));
    end
    check("burst_empty", empty, 1);
    check("burst_stable", stable_err, 0);

    // Write and pop in the same cycle at count 3.
    sent_q.delete();
    manual_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h31 + 8'(i);
      step();
    end
    check("sim_pre_count", fifo_count, 3);
    manual_busy = 1'b0;
    wr_data     = 8'h34;
    step();
    wr_en = 1'b0;
    check("sim_count", fifo_count, 3);
    check("sim_valid", tx_data_valid, 1);
    check("sim_pdata", tx_p_data, 8'h31);
    budget = 0;
    while (sent_q.size() < 4 && budget < 200) begin
      step();
      budget++;
    end
    repeat (12) step();
    check("sim_frames", sent_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      first = (sent_q.size() > i) ? sent_q[i] : 8'hxx;
      check($sformatf("sim_order%0d", i), first, 8'h31 + 8'(i));
    end

    // Busy never acknowledges: retry after ACK_TIMEOUT cycles without a pop.
    model_en    = 1'b0;
    manual_busy = 1'b1;
    wr_en       = 1'b1;
    wr_data     = 8'h5A;
    step();
    wr_data = 8'h6B;
    step();
    wr_en       = 1'b0;
    manual_busy = 1'b0;
    step();
    check("ack_first_valid", tx_data_valid, 1);
    check("ack_first_pdata", tx_p_data, 8'h5A);
    check("ack_first_count", fifo_count, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("ack_wait%0d_valid", i), tx_data_valid, 0);
      check($sformatf("ack_wait%0d_err", i), ack_err, 0);
    end
    step();
    check("ack_err_pulse", ack_err, 1);
    check("ack_retry_valid", tx_data_valid, 1);
    check("ack_retry_pdata", tx_p_data, 8'h5A);
    check("ack_retry_count", fifo_count, 1);
    step();
    check("ack_err_width", ack_err, 0);
    manual_busy = 1'b1;
    repeat (4) step();
    check("ack_busy_count", fifo_count, 1);
    check("ack_busy_valid", tx_data_valid, 0);
    manual_busy = 1'b0;
    step();
    check("b2b_valid_early", tx_data_valid, 0);
    step();
    check("b2b_valid", tx_data_valid, 1);
    check("b2b_pdata", tx_p_data, 8'h6B);
    check("b2b_count", fifo_count, 0);
    step();
    manual_busy = 1'b1;
    repeat (2) step();
    manual_busy = 1'b0;
    repeat (4) step();

    // Reset while in WAIT_DONE with five bytes still queued.
    manual_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h40 + 8'(i);
      step();
    end
    wr_en       = 1'b0;
    manual_busy = 1'b0;
    step();
    check("mid_valid", tx_data_valid, 1);
    step();
    manual_busy = 1'b1;
    repeat (2) step();
    check("mid_count", fifo_count, 5);
    rst = 1'b0;
    repeat (2) step();
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_pdata", tx_p_data, 0);
    check("mid_rst_valid", tx_data_valid, 0);
    rst = 1'b1;
    vc  = valid_cnt;
    step();
    manual_busy = 1'b0;
    repeat (10) step();
    check("mid_no_launch", valid_cnt, vc);
    check("mid_empty_after", empty, 1);

    check("valid_rules", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_feeder
